shift_seq_ctrl: RTL

//   Sequencer that loads a parallel word into the serial-in shift_register, one bit per enabled

---
 rtl/shift_seq_ctrl_if.sv | 35 +++
 rtl/shift_seq_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Word handshake and serial-drive bundle between a word producer and shift_seq_ctrl.
// The abort/aborted pair exists only when SHIFT_SEQ_ABORT_EN is defined.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             ser_data;
  logic             shift_en;
  logic             busy;
  logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output word_in, word_valid, abort,
    input  word_ready, ser_data, shift_en, busy, done, aborted
  );
  modport slave (
    input  word_in, word_valid, abort,
    output word_ready, ser_data, shift_en, busy, done, aborted
  );
`else
  modport master (
    output word_in, word_valid,
    input  word_ready, ser_data, shift_en, busy, done
  );
  modport slave (
    input  word_in, word_valid,
    output word_ready, ser_data, shift_en, busy, done
  );
`endif
endinterface

// File: rtl/shift_seq_ctrl.sv
// Loads a parallel word MSB-first into a downstream serial-in shift register.
// Optional abort path enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input logic             clk,
  input logic             rst_n,
  shift_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + GAP + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_shift_en;
  logic             r_ser;
  logic             w_en;
  logic             w_bit;
  logic             w_abort;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             r_aborted;

  assign w_abort     = bus.abort;
  assign bus.aborted = r_aborted;
`else
  assign w_abort     = 1'b0;
`endif

  // The hold register shifts left each SHIFT cycle, so its MSB is always the next bit out.
  assign w_en  = (r_state == S_SHIFT);
  assign w_bit = w_en & r_hold[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      r_aborted <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.word_valid) begin
            r_hold  <= bus.word_in;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_abort) begin
            r_cnt     <= '0;
            r_state   <= S_IDLE;
`ifdef SHIFT_SEQ_ABORT_EN
            r_aborted <= 1'b1;
`endif
          end else if (r_cnt == LAST_SHIFT) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_hold <= r_hold << 1;
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_cnt     <= '0;
            r_state   <= S_IDLE;
`ifdef SHIFT_SEQ_ABORT_EN
            r_aborted <= 1'b1;
`endif
          end else if (r_cnt == LAST_GAP) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Retimed to the falling edge so clk&shift_en downstream never glitches while clk is high.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_en <= 1'b0;
      r_ser      <= 1'b0;
    end else begin
      r_shift_en <= w_en;
      r_ser      <= w_bit;
    end
  end

  assign bus.word_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.shift_en   = r_shift_en;
  assign bus.ser_data   = r_ser;

endmodule
